code_serializer: RTL and testbench

Parallel-to-serial code feeder that sits directly upstream of the 16-state serial code-detector FSM. It accepts a 16-bit access code word from the keypad/entry logic over a valid/ready handshake and shifts it out MSB-first on a single-bit line, one bit per programmable bit period. Between frames the line idles high, which holds the detector in its initial state. A lockout input from the downstream buzzer/lock logic blocks new code entry while asserted.

---
 rtl/code_serializer.sv | 117 +++++++++++
 tb/tb_code_serializer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_serializer.sv
// Parallel-to-serial access-code feeder: accepts a word over valid/ready and shifts it
// out MSB-first, one bit per BIT_CYCLES clocks, then idles high for GAP_CYCLES clocks.
module code_serializer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned BIT_CYCLES = 1,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_valid,
  output logic             code_ready,
  input  logic             lock,
  output logic             ser_out,
  output logic             ser_active,
  output logic             frame_done
);

  localparam int unsigned BW = $clog2(WIDTH);
  localparam int unsigned PW = $clog2(BIT_CYCLES) + 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES) + 1;

  localparam logic [BW-1:0] BIT_TC = BW'(WIDTH - 1);
  localparam logic [PW-1:0] PRE_TC = PW'(BIT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_TC = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             ser_q, ser_d;
  logic             act_q, act_d;
  logic             done_q, done_d;

  assign code_ready = (state_q == IDLE) && !lock;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    pre_d   = pre_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (code_valid && code_ready) begin
          shift_d = code_in;
          bit_d   = '0;
          pre_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (pre_q == PRE_TC) begin
          pre_d   = '0;
          shift_d = {shift_q[WIDTH-2:0], 1'b1};
          if (bit_q == BIT_TC) begin
            bit_d   = '0;
            gap_d   = '0;
            state_d = GAP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          pre_d = pre_q + PW'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_TC) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so they line up with the state they describe.
    ser_d  = (state_d == SHIFT) ? shift_d[WIDTH-1] : 1'b1;
    act_d  = (state_d == SHIFT);
    done_d = (state_q == SHIFT) && (state_d == GAP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shift_q <= '1;
      bit_q   <= '0;
      pre_q   <= '0;
      gap_q   <= '0;
      ser_q   <= 1'b1;
      act_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      pre_q   <= pre_d;
      gap_q   <= gap_d;
      ser_q   <= ser_d;
      act_q   <= act_d;
      done_q  <= done_d;
    end
  end

  assign ser_out    = ser_q;
  assign ser_active = act_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_code_serializer.sv
// Self-checking bench for code_serializer: default instance plus a BIT_CYCLES=3 instance,
// compared against a frame-timing model derived from the handshake cycle.
module tb_code_serializer;

  localparam int W = 16;
  localparam int G = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] code_in0, code_in3;
  logic         valid0, valid3, lock0, lock3;
  logic         rdy0, rdy3, ser0, ser3, act0, act3, fd0, fd3;

  code_serializer #(.WIDTH(W), .BIT_CYCLES(1), .GAP_CYCLES(G)) dut0 (
    .clk(clk), .rst(rst), .code_in(code_in0), .code_valid(valid0), .code_ready(rdy0),
    .lock(lock0), .ser_out(ser0), .ser_active(act0), .frame_done(fd0)
  );

  code_serializer #(.WIDTH(W), .BIT_CYCLES(3), .GAP_CYCLES(G)) dut3 (
    .clk(clk), .rst(rst), .code_in(code_in3), .code_valid(valid3), .code_ready(rdy3),
    .lock(lock3), .ser_out(ser3), .ser_active(act3), .frame_done(fd3)
  );

  task automatic drive(input bit which, input logic [W-1:0] w, input logic v, input logic l);
    if (which) begin
      code_in3 = w; valid3 = v; lock3 = l;
    end else begin
      code_in0 = w; valid0 = v; lock0 = l;
    end
  endtask

  // {ser_out, ser_active, frame_done, code_ready}
  function automatic logic [3:0] obs(input bit which);
    return which ? {ser3, act3, fd3, rdy3} : {ser0, act0, fd0, rdy0};
  endfunction

  // Runs a frame whose handshake edge has just occurred; t counts cycles after the handshake.
  // Lock is high for lock_on <= t < lock_off; code_in is scrambled after acceptance.
  task automatic exercise_frame(input bit which, input logic [W-1:0] w, input int lock_on,
                                input int lock_off, input bit chain, input logic [W-1:0] next_w);
    int bc, bits, last;
    logic lk;
    logic [3:0] exp;
    bc   = which ? 3 : 1;
    bits = W * bc;
    last = bits + G + 1;
    for (int t = 1; t <= last; t++) begin
      #1;
      lk = (t >= lock_on) && (t < lock_off);
      if (t == last && chain) drive(which, next_w, 1'b1, lk);
      else drive(which, W'($urandom), 1'b0, lk);
      @(negedge clk);
      if (t <= bits) exp = {w[W-1-(t-1)/bc], 1'b1, 1'b0, 1'b0};
      else exp = {1'b1, 1'b0, (t == bits + 1), (t == last) && !lk};
      checks++;
      if (obs(which) !== exp) begin
        failures++;
        $display("FAIL frame dut%0d word=%h t=%0d got=%b expected=%b", which ? 3 : 1, w, t,
                 obs(which), exp);
      end
      if (t != last) @(posedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, '0, 1'b0, 1'b0);
    #12;
    checks++;
    if (obs(1'b0) !== 4'b1001 || obs(1'b1) !== 4'b1001) begin
      failures++;
      $display("FAIL reset_state got=%b/%b expected=1001", obs(1'b0), obs(1'b1));
    end
    lock0 = 1'b1;
    #1;
    checks++;
    if (rdy0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_lock_ready got=%b expected=0", rdy0);
    end
    lock0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs(1'b0) !== 4'b1001) begin
      failures++;
      $display("FAIL after_release got=%b expected=1001", obs(1'b0));
    end
  endtask

  task automatic test_basic(input bit which, input logic [W-1:0] w);
    @(posedge clk);
    #1 drive(which, w, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (obs(which) !== 4'b1001) begin
      failures++;
      $display("FAIL handshake_cycle word=%h got=%b expected=1001", w, obs(which));
    end
    @(posedge clk);
    exercise_frame(which, w, 0, 0, 1'b0, '0);
  endtask

  task automatic test_random_lock;
    bit which;
    logic [W-1:0] w;
    int last, lon, loff;
    for (int i = 0; i < 8; i++) begin
      which = bit'(i % 2);
      w     = W'($urandom);
      last  = W * (which ? 3 : 1) + G + 1;
      lon   = $urandom_range(1, last);
      loff  = $urandom_range(lon, last + 1);
      @(posedge clk);
      #1 drive(which, w, 1'b1, 1'b0);
      @(posedge clk);
      exercise_frame(which, w, lon, loff, 1'b0, '0);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] w [3];
    for (int i = 0; i < 3; i++) w[i] = W'($urandom);
    @(posedge clk);
    #1 drive(1'b0, w[0], 1'b1, 1'b0);
    @(posedge clk);
    exercise_frame(1'b0, w[0], 0, 0, 1'b1, w[1]);
    @(posedge clk);
    exercise_frame(1'b0, w[1], 0, 0, 1'b1, w[2]);
    @(posedge clk);
    exercise_frame(1'b0, w[2], 0, 0, 1'b0, '0);
  endtask

  task automatic test_lock_entry;
    logic [W-1:0] w;
    w = W'($urandom);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1 drive(1'b0, w, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (rdy0 !== 1'b0 || act0 !== 1'b0) begin
        failures++;
        $display("FAIL locked_entry c=%0d ready=%b active=%b expected 0/0", c, rdy0, act0);
      end
    end
    @(posedge clk);
    #1 drive(1'b0, w, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b1) begin
      failures++;
      $display("FAIL unlock_ready got=%b expected=1", rdy0);
    end
    @(posedge clk);
    exercise_frame(1'b0, w, 0, 0, 1'b0, '0);
  endtask

  task automatic test_lock_midframe;
    logic [W-1:0] w;
    w = W'($urandom);
    @(posedge clk);
    #1 drive(1'b0, w, 1'b1, 1'b0);
    @(posedge clk);
    exercise_frame(1'b0, w, 6, 1000, 1'b0, '0);
    @(posedge clk);
    #1 drive(1'b0, w, 1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if (rdy0 !== 1'b0 || act0 !== 1'b0) begin
      failures++;
      $display("FAIL lock_hold ready=%b active=%b expected 0/0", rdy0, act0);
    end
    @(posedge clk);
    #1 drive(1'b0, w, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (obs(1'b0) !== 4'b1001) begin
      failures++;
      $display("FAIL lock_release got=%b expected=1001", obs(1'b0));
    end
  endtask

  task automatic test_reset_midframe;
    logic [W-1:0] w, w2;
    w  = W'($urandom);
    w2 = W'($urandom);
    @(posedge clk);
    #1 drive(1'b0, w, 1'b1, 1'b0);
    @(posedge clk);
    for (int t = 1; t <= 8; t++) begin
      #1 drive(1'b0, W'($urandom), 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (obs(1'b0) !== {w[W-t], 3'b100}) begin
        failures++;
        $display("FAIL pre_abort t=%0d got=%b expected=%b", t, obs(1'b0), {w[W-t], 3'b100});
      end
      if (t != 8) @(posedge clk);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (obs(1'b0) !== 4'b1001) begin
      failures++;
      $display("FAIL async_abort got=%b expected=1001", obs(1'b0));
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (obs(1'b0) !== 4'b1001) begin
        failures++;
        $display("FAIL residual c=%0d got=%b expected=1001", c, obs(1'b0));
      end
    end
    test_basic(1'b0, w2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic(1'b0, 16'h1732);
    test_basic(1'b1, 16'h8001);
    test_random_lock();
    test_back_to_back();
    test_lock_entry();
    test_lock_midframe();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
